// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the frame-level sequence-detector
// controller. Holds the controller state encoding and default widths.
package seq_det_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_CNT_W  = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/seq_det_serializer.sv
// seq_det_serializer: parallel-in, serial-out shift register, MSB first.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_load         : capture i_word, bit index restarts at DATA_W-1
//   i_shift        : shift left one bit, bit index counts down
//   i_word         : word to capture
//   o_msb          : current serial bit (shreg MSB)
//   o_last         : current bit is the last bit of the word
// Load takes priority over shift, so a reload on the last-bit cycle
// streams the next word with no gap.
module seq_det_serializer
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_word,
  output logic              o_msb,
  output logic              o_last
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;

  always_comb begin
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    if (i_load) begin
      shreg_d   = i_word;
      bit_idx_d = IDX_W'(DATA_W - 1);
    end else if (i_shift) begin
      shreg_d = shreg_q << 1;
      if (bit_idx_q != '0) bit_idx_d = bit_idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shreg_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  assign o_msb  = shreg_q[DATA_W-1];
  assign o_last = (bit_idx_q == '0);

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: feeds a bit-serial pattern detector from a byte stream,
// one frame at a time, and counts the detector's hits over the frame.
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_start, i_frame_len : frame request and word count (taken in IDLE)
//   i_word, i_word_valid, o_word_ready : upstream word handshake
//   o_det_data, o_det_valid, o_det_clear : serial feed to the detector
//   i_pattern_found      : detector hit pulse
//   o_busy, o_done       : not-idle level, end-of-frame pulse
//   o_hit_count, o_hit_ovf : saturating hit count and sticky saturation flag
// All outputs come from registers only; i_word_valid never reaches o_det_*.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DRAIN_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_frame_len,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_det_data,
  output logic              o_det_valid,
  output logic              o_det_clear,
  input  logic              i_pattern_found,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_hit_count,
  output logic              o_hit_ovf
);

  localparam int              DRN_W   = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_left_q, len_left_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic              hit_ovf_q, hit_ovf_d;

  logic word_ready;
  logic ser_load, ser_shift, ser_msb, ser_last;
  logic last_word;
  logic count_en;

  assign last_word = (len_left_q == LEN_W'(1));
  assign ser_load  = word_ready & i_word_valid;

  always_comb begin
    state_d    = state_q;
    len_left_d = len_left_q;
    drain_d    = drain_q;
    hit_cnt_d  = hit_cnt_q;
    hit_ovf_d  = hit_ovf_q;
    word_ready = 1'b0;
    ser_shift  = 1'b0;
    count_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          len_left_d = i_frame_len;
          hit_cnt_d  = '0;
          hit_ovf_d  = 1'b0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        state_d = (len_left_q == '0) ? DONE : LOAD;
      end
      LOAD: begin
        count_en   = 1'b1;
        word_ready = 1'b1;
        if (i_word_valid) state_d = SHIFT;
      end
      SHIFT: begin
        count_en  = 1'b1;
        ser_shift = 1'b1;
        if (ser_last) begin
          len_left_d = len_left_q - LEN_W'(1);
          if (last_word) begin
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            // Offer the next word on the last bit so a waiting source
            // streams without a bubble.
            word_ready = 1'b1;
            if (!i_word_valid) state_d = LOAD;
          end
        end
      end
      DRAIN: begin
        count_en = 1'b1;
        if (drain_q == DRN_W'(DRAIN_CYC - 1)) state_d = DONE;
        else                                  drain_d = drain_q + DRN_W'(1);
      end
      DONE: begin
        count_en = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (count_en && i_pattern_found) begin
      if (hit_cnt_q == CNT_MAX) begin
        hit_ovf_d = 1'b1;
      end else begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
        if (hit_cnt_q == CNT_MAX - CNT_W'(1)) hit_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      len_left_q <= '0;
      drain_q    <= '0;
      hit_cnt_q  <= '0;
      hit_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_left_q <= len_left_d;
      drain_q    <= drain_d;
      hit_cnt_q  <= hit_cnt_d;
      hit_ovf_q  <= hit_ovf_d;
    end
  end

  seq_det_serializer #(.DATA_W(DATA_W)) u_ser (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (ser_load),
    .i_shift (ser_shift),
    .i_word  (i_word),
    .o_msb   (ser_msb),
    .o_last  (ser_last)
  );

  assign o_word_ready = word_ready;
  assign o_det_valid  = (state_q == SHIFT);
  assign o_det_data   = o_det_valid & ser_msb;
  assign o_det_clear  = (state_q == CLEAR);
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);
  assign o_hit_count  = hit_cnt_q;
  assign o_hit_ovf    = hit_ovf_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with a small 101001 detector model
// (overlapping, one-cycle output latency, cleared by o_det_clear).
module tb_seq_detect_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_frame_len = '0;
  logic [7:0] i_word = '0;
  logic       i_word_valid = 1'b0;
  logic       o_word_ready, o_det_data, o_det_valid, o_det_clear;
  logic       i_pattern_found;
  logic       o_busy, o_done, o_hit_ovf;
  logic [5:0] o_hit_count;

  logic       frc = 1'b0;
  logic       det_hit;
  logic [4:0] hist;

  int errs = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  seq_detect_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_frame_len(i_frame_len), .i_word(i_word), .i_word_valid(i_word_valid),
    .o_word_ready(o_word_ready), .o_det_data(o_det_data),
    .o_det_valid(o_det_valid), .o_det_clear(o_det_clear),
    .i_pattern_found(i_pattern_found), .o_busy(o_busy), .o_done(o_done),
    .o_hit_count(o_hit_count), .o_hit_ovf(o_hit_ovf)
  );

  always @(posedge i_clk) begin
    if (i_reset || o_det_clear) begin
      hist    <= '0;
      det_hit <= 1'b0;
    end else begin
      det_hit <= o_det_valid && ({hist, o_det_data} == 6'b101001);
      if (o_det_valid) hist <= {hist[3:0], o_det_data};
    end
  end

  assign i_pattern_found = frc | det_hit;

  // Per-frame trace, indexed by cycle (cycle 0 = start cycle).
  logic [7:0]   words [16];
  logic [255:0] dv_mask, rdy_mask, clr_mask, bits;
  int           nbits, done_cyc, done_cnt;
  logic [5:0]   cnt_at_done, cnt_at_clear, pre_rst_cnt;
  logic         ovf_at_done, ovf_at_clear;
  logic [11:0]  rst_vec;

  task automatic run_frame(input int len, input int gap_start, input int gap_len,
                           input int frc_start, input int frc_len,
                           input int busy_start, input int rst_cyc,
                           input int max_cyc);
    int widx;
    widx = 0;
    dv_mask = '0; rdy_mask = '0; clr_mask = '0; bits = '0; nbits = 0;
    done_cyc = -1; done_cnt = 0; cnt_at_done = '0; ovf_at_done = 1'b0;
    cnt_at_clear = '1; ovf_at_clear = 1'b1; rst_vec = '1; pre_rst_cnt = '0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge i_clk);
      if (o_det_valid) begin
        dv_mask[c] = 1'b1;
        bits = {bits[254:0], o_det_data};
        nbits++;
      end
      if (o_word_ready) rdy_mask[c] = 1'b1;
      if (o_det_clear)  clr_mask[c] = 1'b1;
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c; cnt_at_done = o_hit_count; ovf_at_done = o_hit_ovf;
        end
      end
      if (c == 1) begin cnt_at_clear = o_hit_count; ovf_at_clear = o_hit_ovf; end
      if (c == rst_cyc) pre_rst_cnt = o_hit_count;
      if (c == rst_cyc + 1)
        rst_vec = {o_busy, o_word_ready, o_det_valid, o_det_data, o_det_clear,
                   o_done, o_hit_ovf, o_hit_count[4:0]} | {11'd0, o_hit_count[5]};
      i_reset      = (c == rst_cyc);
      i_start      = (c == 0) || (c == busy_start);
      i_frame_len  = (c == busy_start) ? 8'd5 : len[7:0];
      i_word_valid = (widx < len) && !(c >= gap_start && c < gap_start + gap_len);
      i_word       = i_word_valid ? words[widx] : 8'h5A;
      frc          = (c >= frc_start) && (c < frc_start + frc_len);
      if (o_word_ready && i_word_valid) widx++;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    @(negedge i_clk);
    i_start = 1'b0; i_word_valid = 1'b0; frc = 1'b0; i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_busy, o_word_ready, o_det_valid, o_det_data, o_det_clear, o_done,
         o_hit_ovf, o_hit_count} !== 12'd0) begin
      errs++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b dv=%b dd=%b clr=%b done=%b ovf=%b cnt=%0d want all 0",
               o_busy, o_word_ready, o_det_valid, o_det_data, o_det_clear, o_done, o_hit_ovf, o_hit_count);
    end
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_single();
    words[0] = 8'hA4;
    run_frame(1, 1000, 0, 1000, 0, -1, -1, 40);
    checks++; if (clr_mask !== 256'h2) begin errs++; $display("FAIL single_clear: got %h want 2", clr_mask); end
    checks++; if (rdy_mask !== 256'h4) begin errs++; $display("FAIL single_ready: got %h want 4", rdy_mask); end
    checks++; if (dv_mask !== 256'h7F8) begin errs++; $display("FAIL single_valid: got %h want 7f8", dv_mask); end
    checks++; if (bits[7:0] !== 8'hA4 || nbits != 8) begin errs++; $display("FAIL single_bits: got %h/%0d want a4/8", bits[7:0], nbits); end
    checks++; if (done_cyc != 13 || done_cnt != 1) begin errs++; $display("FAIL single_done: got cyc %0d n %0d want 13 1", done_cyc, done_cnt); end
    checks++; if (cnt_at_done !== 6'd1 || ovf_at_done !== 1'b0) begin errs++; $display("FAIL single_hits: got %0d ovf %b want 1 0", cnt_at_done, ovf_at_done); end
    // Hits while idle are ignored and the last count holds.
    frc = 1'b1;
    repeat (3) @(negedge i_clk);
    frc = 1'b0;
    @(negedge i_clk);
    checks++; if (o_hit_count !== 6'd1) begin errs++; $display("FAIL idle_hits_ignored: got %0d want 1", o_hit_count); end
  endtask

  task automatic test_back_to_back();
    words[0] = 8'hA4; words[1] = 8'hA5; words[2] = 8'h29;
    run_frame(3, 1000, 0, 1000, 0, -1, -1, 60);
    checks++; if (dv_mask !== 256'h7FFFFF8) begin errs++; $display("FAIL b2b_valid: got %h want 7fffff8", dv_mask); end
    checks++; if (rdy_mask !== 256'h40404) begin errs++; $display("FAIL b2b_ready: got %h want 40404", rdy_mask); end
    checks++; if (bits[23:0] !== 24'hA4A529 || nbits != 24) begin errs++; $display("FAIL b2b_bits: got %h/%0d want a4a529/24", bits[23:0], nbits); end
    checks++; if (done_cyc != 29 || done_cnt != 1) begin errs++; $display("FAIL b2b_done: got cyc %0d n %0d want 29 1", done_cyc, done_cnt); end
    // Stream 10100100_10100101_00101001 holds 101001 ending at bit offsets
    // 5, 13, 18 and 23 (the 13 and 18 matches share bit 13).
    checks++; if (cnt_at_done !== 6'd4) begin errs++; $display("FAIL b2b_hits: got %0d want 4", cnt_at_done); end
  endtask

  task automatic test_stall();
    words[0] = 8'hC3; words[1] = 8'h3C;
    run_frame(2, 10, 3, 1000, 0, -1, -1, 60);
    checks++; if (dv_mask !== 256'h3FC7F8) begin errs++; $display("FAIL stall_valid: got %h want 3fc7f8", dv_mask); end
    checks++; if (rdy_mask !== 256'h3C04) begin errs++; $display("FAIL stall_ready: got %h want 3c04", rdy_mask); end
    checks++; if (bits[15:0] !== 16'hC33C) begin errs++; $display("FAIL stall_bits: got %h want c33c", bits[15:0]); end
    checks++; if (done_cyc != 24 || done_cnt != 1) begin errs++; $display("FAIL stall_done: got cyc %0d n %0d want 24 1", done_cyc, done_cnt); end
  endtask

  task automatic test_zero_len();
    // A hit forced during CLEAR must not count.
    run_frame(0, 1000, 0, 1, 1, -1, -1, 20);
    checks++; if (clr_mask !== 256'h2) begin errs++; $display("FAIL zero_clear: got %h want 2", clr_mask); end
    checks++; if (done_cyc != 2 || done_cnt != 1) begin errs++; $display("FAIL zero_done: got cyc %0d n %0d want 2 1", done_cyc, done_cnt); end
    checks++; if (dv_mask !== '0 || rdy_mask !== '0) begin errs++; $display("FAIL zero_no_data: got dv %h rdy %h want 0 0", dv_mask, rdy_mask); end
    checks++; if (cnt_at_done !== 6'd0) begin errs++; $display("FAIL zero_hits: got %0d want 0", cnt_at_done); end
  endtask

  task automatic test_busy_start();
    words[0] = 8'hA4;
    run_frame(1, 1000, 0, 1000, 0, 5, -1, 40);
    checks++; if (done_cyc != 13 || done_cnt != 1) begin errs++; $display("FAIL busy_start_done: got cyc %0d n %0d want 13 1", done_cyc, done_cnt); end
    checks++; if (bits[7:0] !== 8'hA4 || nbits != 8) begin errs++; $display("FAIL busy_start_bits: got %h/%0d want a4/8", bits[7:0], nbits); end
    checks++; if (o_busy !== 1'b0) begin errs++; $display("FAIL busy_start_idle: got busy %b want 0", o_busy); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 10; i++) words[i] = 8'h00;
    run_frame(10, 1000, 0, 3, 70, -1, -1, 120);
    checks++; if (done_cyc != 85) begin errs++; $display("FAIL sat_done: got cyc %0d want 85", done_cyc); end
    checks++; if (cnt_at_done !== 6'd63 || ovf_at_done !== 1'b1) begin errs++; $display("FAIL sat_count: got %0d ovf %b want 63 1", cnt_at_done, ovf_at_done); end
    checks++; if (o_hit_count !== 6'd63 || o_hit_ovf !== 1'b1) begin errs++; $display("FAIL sat_hold: got %0d ovf %b want 63 1", o_hit_count, o_hit_ovf); end
    run_frame(0, 1000, 0, 1000, 0, -1, -1, 20);
    checks++; if (cnt_at_clear !== 6'd0 || ovf_at_clear !== 1'b0) begin errs++; $display("FAIL sat_restart_clear: got %0d ovf %b want 0 0", cnt_at_clear, ovf_at_clear); end
  endtask

  task automatic test_reset_mid();
    words[0] = 8'hA4; words[1] = 8'hA5;
    run_frame(2, 1000, 0, 3, 2, -1, 6, 20);
    checks++; if (pre_rst_cnt !== 6'd2) begin errs++; $display("FAIL rst_pre_count: got %0d want 2", pre_rst_cnt); end
    checks++; if (rst_vec !== 12'd0) begin errs++; $display("FAIL rst_outputs: got %h want 0", rst_vec); end
    checks++; if (done_cnt != 0) begin errs++; $display("FAIL rst_no_done: got %0d want 0", done_cnt); end
    words[0] = 8'hA4;
    run_frame(1, 1000, 0, 1000, 0, -1, -1, 40);
    checks++; if (done_cyc != 13 || cnt_at_done !== 6'd1) begin errs++; $display("FAIL rst_after_frame: got cyc %0d cnt %0d want 13 1", done_cyc, cnt_at_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_zero_len();
    test_busy_start();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
